// File: rtl/proc_pkg.sv
// Shared types and the round-robin pick helper for the header-processor scheduler.
package proc_pkg;

    localparam int PROC_PORTS  = 4;
    localparam int HDR_MAX_LEN = 8;
    localparam int BYTE_BUS    = 8;
    localparam int MAX_PORTS   = 32;
    localparam int MAX_W       = $clog2(MAX_PORTS);

    localparam logic [BYTE_BUS-1:0] ZERO_BYTE = '0;

    typedef logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0] hdr_t;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } sched_state_t;

    // First requester after 'last', wrapping mod n; -1 when nothing requests.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic int rr_pick(input logic [MAX_PORTS-1:0] req, input int n, input int last);
        int pick;
        int idx;
        pick = -1;
        for (int k = MAX_PORTS; k >= 1; k--) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (req[idx[MAX_W-1:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/proc_latch.sv
// One producer's header slot: captures on write when empty, frees on read.
module proc_latch
    import proc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wr_i,
    input  hdr_t hdr_i,
    input  logic rd_i,
    output logic empty_o,
    output hdr_t hdr_o
);

    logic r_full;
    hdr_t r_hdr;

    // A write into an occupied slot is a producer error and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_hdr  <= '0;
        end else if (rd_i) begin
            r_full <= 1'b0;
        end else if (wr_i && !r_full) begin
            r_full <= 1'b1;
            r_hdr  <= hdr_i;
        end
    end

    assign empty_o = ~r_full;
    assign hdr_o   = r_hdr;

endmodule

// File: rtl/proc_sched.sv
// Round-robin drain of per-port header slots into one registered valid/ready stage.
// state  | meaning
// S_IDLE | nothing presented; grant as soon as any slot is full
// S_HOLD | header presented; hold until ready_i, then grant next or go idle
module proc_sched
    import proc_pkg::*;
#(
    parameter int N_PORTS = PROC_PORTS,
    localparam int PORT_W = $clog2(N_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PORTS-1:0]   wr_i,
    input  hdr_t [N_PORTS-1:0]   pkt_hdr_i,
    output logic [N_PORTS-1:0]   full_o,
    output logic                 valid_o,
    output hdr_t                 pkt_hdr_o,
    output logic [PORT_W-1:0]    port_o,
    input  logic                 ready_i
);

    sched_state_t        r_state;
    logic                r_valid;
    hdr_t                r_hdr;
    logic [PORT_W-1:0]   r_port;
    logic [PORT_W-1:0]   r_last;

    logic [N_PORTS-1:0]  w_empty;
    logic [N_PORTS-1:0]  w_full;
    logic [N_PORTS-1:0]  w_rd;
    hdr_t                w_slot_hdr [N_PORTS];
    int                  w_pick;
    logic                w_found;
    logic [PORT_W-1:0]   w_idx;
    logic                w_take;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_slot
        proc_latch u_latch (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (wr_i[g]),
            .hdr_i   (pkt_hdr_i[g]),
            .rd_i    (w_rd[g]),
            .empty_o (w_empty[g]),
            .hdr_o   (w_slot_hdr[g])
        );
    end

    assign w_full  = ~w_empty;
    assign w_pick  = rr_pick(MAX_PORTS'(w_full), N_PORTS, int'(r_last));
    assign w_found = (w_pick >= 0);
    assign w_idx   = PORT_W'(w_pick);
    // A grant fires whenever the output stage is free or being emptied this cycle.
    assign w_take  = w_found && ((r_state == S_IDLE) || ready_i);
    assign w_rd    = w_take ? (N_PORTS'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_hdr   <= '0;
            r_port  <= '0;
            r_last  <= PORT_W'(N_PORTS - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                        r_hdr   <= w_slot_hdr[w_idx];
                        r_port  <= w_idx;
                        r_last  <= w_idx;
                    end
                end
                S_HOLD: begin
                    if (w_take) begin
                        r_hdr  <= w_slot_hdr[w_idx];
                        r_port <= w_idx;
                        r_last <= w_idx;
                    end else if (ready_i) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_hdr   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign full_o    = w_full;
    assign valid_o   = r_valid;
    assign pkt_hdr_o = r_hdr;
    assign port_o    = r_port;

endmodule

// File: tb/tb_proc_sched.sv
// Directed vector bench for proc_sched: reset, single, fairness, backpressure, wrap, reset mid-op.
module tb_proc_sched;
    import proc_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     wr_i;
    hdr_t [3:0]     pkt_hdr_i;
    logic [3:0]     full_o;
    logic           valid_o;
    hdr_t           pkt_hdr_o;
    logic [1:0]     port_o;
    logic           ready_i;

    int n_checks = 0;
    int n_errors = 0;

    proc_sched #(.N_PORTS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (wr_i),
        .pkt_hdr_i (pkt_hdr_i),
        .full_o    (full_o),
        .valid_o   (valid_o),
        .pkt_hdr_o (pkt_hdr_o),
        .port_o    (port_o),
        .ready_i   (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  wr;
        logic [31:0] b0;
        logic        rdy;
        logic [3:0]  ef;
        logic        ev;
        logic [1:0]  ep;
        logic [7:0]  eb;
    } vec_t;

    vec_t vecs [19];

    // Every header is derived from its byte 0 so one byte identifies it end to end.
    function automatic hdr_t mkhdr(input logic [7:0] b);
        hdr_t h;
        for (int k = 0; k < HDR_MAX_LEN; k++) h[k] = b ^ 8'(k << 4);
        return h;
    endfunction

    task automatic chk(input string name, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", name, what, act, exp);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [3:0] wr, input logic [31:0] b0,
                        input logic rdy, input logic [3:0] ef, input logic ev, input logic [1:0] ep,
                        input logic [7:0] eb);
        hdr_t exp_hdr;
        rst     = r;
        wr_i    = wr;
        ready_i = rdy;
        for (int p = 0; p < 4; p++) pkt_hdr_i[p] = mkhdr(b0[8*p +: 8]);
        @(posedge clk);
        #1;
        exp_hdr = ev ? mkhdr(eb) : '0;
        chk(name, "full",  64'(full_o),    64'(ef));
        chk(name, "valid", 64'(valid_o),   64'(ev));
        chk(name, "port",  64'(port_o),    64'(ep));
        chk(name, "hdr",   64'(pkt_hdr_o), 64'(exp_hdr));
    endtask

    initial begin
        vecs[0]  = '{"reset",       1'b1, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{"single_wr",   1'b0, 4'b0001, 32'h0000_00A5, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
        vecs[2]  = '{"single_vld",  1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA5};
        vecs[3]  = '{"single_idle", 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[4]  = '{"reset2",      1'b1, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[5]  = '{"fair_wr",     1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b1111, 1'b0, 2'd0, 8'h00};
        vecs[6]  = '{"fair_p0",     1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b1110, 1'b1, 2'd0, 8'h10};
        vecs[7]  = '{"fair_p1",     1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b1100, 1'b1, 2'd1, 8'h11};
        vecs[8]  = '{"fair_p2",     1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h12};
        vecs[9]  = '{"fair_p3",     1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h13};
        vecs[10] = '{"fair_idle",   1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h00};
        vecs[11] = '{"bp_wr2",      1'b0, 4'b0100, 32'h0042_0000, 1'b0, 4'b0100, 1'b0, 2'd3, 8'h00};
        vecs[12] = '{"bp_hold1",    1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h42};
        vecs[13] = '{"bp_wr1",      1'b0, 4'b0010, 32'h0000_1100, 1'b0, 4'b0010, 1'b1, 2'd2, 8'h42};
        vecs[14] = '{"bp_wr_full",  1'b0, 4'b0010, 32'h0000_9900, 1'b0, 4'b0010, 1'b1, 2'd2, 8'h42};
        vecs[15] = '{"bp_hold4",    1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b1, 2'd2, 8'h42};
        vecs[16] = '{"bp_hold5",    1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b1, 2'd2, 8'h42};
        vecs[17] = '{"bp_accept",   1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11};
        vecs[18] = '{"bp_idle",     1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h00};

        rst = 1'b1; wr_i = '0; ready_i = 1'b0; pkt_hdr_i = '0;

        for (int i = 0; i < 19; i++)
            step(vecs[i].name, vecs[i].rst, vecs[i].wr, vecs[i].b0, vecs[i].rdy,
                 vecs[i].ef, vecs[i].ev, vecs[i].ep, vecs[i].eb);

        // Wrap: park last grant on port 3, then ports 1/3 plus a late port-0 refill.
        step("wrap_wr3",  1'b0, 4'b1000, 32'h3300_0000, 1'b1, 4'b1000, 1'b0, 2'd1, 8'h00);
        step("wrap_g3",   1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h33);
        step("wrap_wr13", 1'b0, 4'b1010, 32'h5300_5100, 1'b1, 4'b1010, 1'b0, 2'd3, 8'h00);
        step("wrap_p1",   1'b0, 4'b0001, 32'h0000_0050, 1'b1, 4'b1001, 1'b1, 2'd1, 8'h51);
        step("wrap_p3",   1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h53);
        step("wrap_p0",   1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h50);
        step("wrap_idle", 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);

        // Reset while presenting with three slots still occupied.
        step("mid_wr",    1'b0, 4'b1111, 32'h2322_2120, 1'b0, 4'b1111, 1'b0, 2'd0, 8'h00);
        step("mid_vld",   1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b1101, 1'b1, 2'd1, 8'h21);
        step("mid_rst",   1'b1, 4'b1111, 32'h2322_2120, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        step("mid_after", 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
        step("mid_quiet", 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
